vscpu_mem_responder: RTL and testbench

//  Responder end of the VSCPU agent memory interface. Serves word requests from the CPU core and

---
 rtl/vscpu_mem_responder.sv | 154 +++++++++++++++
 tb/tb_vscpu_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscpu_mem_responder.sv
`timescale 1ns/1ps
// vscpu_mem_responder
// Responder end of the VSCPU agent memory interface. Arbitrates between the
// host loader port (priority) and the CPU port, runs one fixed-latency SRAM
// access at a time and signals completion with a one-cycle vld/ack pulse.
module vscpu_mem_responder #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int SRAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_ctrl_req,
    input  logic                     mem_ctrl_we,
    input  logic [ADDR_W-1:0]        mem_ctrl_addr,
    input  logic [DATA_W-1:0]        mem_ctrl_in,
    output logic [DATA_W-1:0]        mem_ctrl_out,
    output logic                     mem_ctrl_vld,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic [DATA_W-1:0]        host_wdata,
    output logic [DATA_W-1:0]        host_rdata,
    output logic                     host_ack,
    output logic                     sram_csb,
    output logic                     sram_web,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [DATA_W-1:0]        sram_din,
    input  logic [DATA_W-1:0]        sram_dout,
    output logic                     busy
);
    localparam int SA_W  = $clog2(DEPTH);
    localparam int CNT_W = 3;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_host, lat_we, lat_in_range;

    logic               sel_we, sel_in_range;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [DATA_W-1:0]  rd_val;

    logic               csb_n, web_n, vld_n, ack_n, busy_n;
    logic [SA_W-1:0]    addr_n;
    logic [DATA_W-1:0]  din_n, out_n, rdata_n;

    // Request selection: host wins when both ports request together
    always_comb begin
        sel_we       = host_req ? host_we    : mem_ctrl_we;
        sel_addr     = host_req ? host_addr  : mem_ctrl_addr;
        sel_wdata    = host_req ? host_wdata : mem_ctrl_in;
        sel_in_range = ({1'b0, sel_addr} < DEPTH_LIM);
        rd_val       = lat_in_range ? sram_dout : '0;
    end

    // State register, request latch and WAIT down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_host     <= 1'b0;
            lat_we       <= 1'b0;
            lat_in_range <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && (host_req || mem_ctrl_req)) begin
                lat_host     <= host_req;
                lat_we       <= sel_we;
                lat_in_range <= sel_in_range;
            end
            if (state == S_ISSUE)
                cnt <= CNT_W'(SRAM_LAT);
            else if (state == S_WAIT)
                cnt <= cnt - 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (host_req || mem_ctrl_req) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (cnt == CNT_W'(1)) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the ISSUE-cycle SRAM strobe is
    // computed from the live request so it lands in the same edge as the latch
    always_comb begin
        csb_n   = 1'b1;
        web_n   = 1'b1;
        addr_n  = sram_addr;
        din_n   = sram_din;
        vld_n   = 1'b0;
        ack_n   = 1'b0;
        out_n   = mem_ctrl_out;
        rdata_n = host_rdata;
        busy_n  = (next_state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (next_state == S_ISSUE && sel_in_range) begin
                    csb_n  = 1'b0;
                    web_n  = ~sel_we;
                    addr_n = sel_addr[SA_W-1:0];
                    din_n  = sel_wdata;
                end
            end
            S_WAIT: begin
                if (next_state == S_RESP) begin
                    if (lat_host) ack_n = 1'b1;
                    else          vld_n = 1'b1;
                    if (!lat_we) begin
                        if (lat_host) rdata_n = rd_val;
                        else          out_n   = rd_val;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_csb     <= 1'b1;
            sram_web     <= 1'b1;
            sram_addr    <= '0;
            sram_din     <= '0;
            mem_ctrl_vld <= 1'b0;
            host_ack     <= 1'b0;
            mem_ctrl_out <= '0;
            host_rdata   <= '0;
            busy         <= 1'b0;
        end else begin
            sram_csb     <= csb_n;
            sram_web     <= web_n;
            sram_addr    <= addr_n;
            sram_din     <= din_n;
            mem_ctrl_vld <= vld_n;
            host_ack     <= ack_n;
            mem_ctrl_out <= out_n;
            host_rdata   <= rdata_n;
            busy         <= busy_n;
        end
    end
endmodule

// File: tb/tb_vscpu_mem_responder.sv
`timescale 1ns/1ps
// Testbench for vscpu_mem_responder: instance 0 uses SRAM_LAT=1, instance 1
// uses SRAM_LAT=3, each with its own behavioural SRAM. Expected completions
// are queued when a request is driven and checked when vld/ack pulses.
module tb_vscpu_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        c_req   [2];
    logic        c_we    [2];
    logic [13:0] c_addr  [2];
    logic [31:0] c_in    [2];
    logic [31:0] c_out   [2];
    logic        c_vld   [2];
    logic        h_req   [2];
    logic        h_we    [2];
    logic [13:0] h_addr  [2];
    logic [31:0] h_wdata [2];
    logic [31:0] h_rdata [2];
    logic        h_ack   [2];
    logic        csb     [2];
    logic        web     [2];
    logic [9:0]  saddr   [2];
    logic [31:0] din     [2];
    logic [31:0] dout    [2];
    logic        busy    [2];

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int LATP = (g == 0) ? 1 : 3;
        logic [31:0] mem  [1024];
        logic [31:0] pipe [LATP];

        vscpu_mem_responder #(.ADDR_W(14), .DATA_W(32), .DEPTH(1024), .SRAM_LAT(LATP)) dut (
            .clk(clk), .rst(rst[g]),
            .mem_ctrl_req(c_req[g]), .mem_ctrl_we(c_we[g]), .mem_ctrl_addr(c_addr[g]),
            .mem_ctrl_in(c_in[g]), .mem_ctrl_out(c_out[g]), .mem_ctrl_vld(c_vld[g]),
            .host_req(h_req[g]), .host_we(h_we[g]), .host_addr(h_addr[g]),
            .host_wdata(h_wdata[g]), .host_rdata(h_rdata[g]), .host_ack(h_ack[g]),
            .sram_csb(csb[g]), .sram_web(web[g]), .sram_addr(saddr[g]),
            .sram_din(din[g]), .sram_dout(dout[g]), .busy(busy[g])
        );

        // SRAM model: data read at an address edge appears LATP cycles later;
        // non-read cycles push a poison word so mistimed captures are visible
        always @(posedge clk) begin
            if (!csb[g] && !web[g]) mem[saddr[g]] <= din[g];
            pipe[0] <= (!csb[g] && web[g]) ? mem[saddr[g]] : 32'hDEAD_BEEF;
            for (int k = 1; k < LATP; k++) pipe[k] <= pipe[k-1];
        end
        assign dout[g] = pipe[LATP-1];
    end

    typedef struct {
        bit          host;
        logic [31:0] c_out;
        logic [31:0] h_rdata;
        int unsigned cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [2][1024];
    logic [31:0] last_c  [2];
    logic [31:0] last_h  [2];
    logic        prev_vld [2];
    logic        prev_ack [2];

    // Scoreboard: every completion pulse is matched against the queue head
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int i = 0; i < 2; i++) begin
            if (c_vld[i] || h_ack[i]) begin
                checks++;
                have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_pulse inst%0d cyc=%0d vld=%b ack=%b required no pulse",
                             i, cyc, c_vld[i], h_ack[i]);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (c_vld[i] !== !e.host || h_ack[i] !== e.host || c_out[i] !== e.c_out ||
                        h_rdata[i] !== e.h_rdata || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL completion inst%0d got vld=%b ack=%b out=%h rdata=%h cyc=%0d required vld=%b ack=%b out=%h rdata=%h cyc=%0d",
                                 i, c_vld[i], h_ack[i], c_out[i], h_rdata[i], cyc,
                                 !e.host, e.host, e.c_out, e.h_rdata, e.cyc);
                    end
                end
                checks++;
                if ((c_vld[i] && prev_vld[i]) || (h_ack[i] && prev_ack[i])) begin
                    errors++;
                    $display("FAIL pulse_width inst%0d cyc=%0d got 2+ cycle pulse required 1 cycle", i, cyc);
                end
            end
            prev_vld[i] = c_vld[i];
            prev_ack[i] = h_ack[i];
        end
    end

    task automatic push_exp(input int i, input bit host, input bit we, input logic [13:0] a,
                            input logic [31:0] d, input int unsigned ecyc);
        exp_t        e;
        logic [31:0] rv;
        rv = (a < 14'd1024) ? ref_mem[i][a[9:0]] : 32'h0;
        if (we) begin
            if (a < 14'd1024) ref_mem[i][a[9:0]] = d;
        end else if (host) begin
            last_h[i] = rv;
        end else begin
            last_c[i] = rv;
        end
        e.host = host; e.c_out = last_c[i]; e.h_rdata = last_h[i]; e.cyc = ecyc;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input int i, input bit host, input bit we, input logic [13:0] a,
                         input logic [31:0] d);
        if (host) begin h_req[i] = 1'b1; h_we[i] = we; h_addr[i] = a; h_wdata[i] = d; end
        else      begin c_req[i] = 1'b1; c_we[i] = we; c_addr[i] = a; c_in[i]    = d; end
    endtask

    task automatic wait_pulse(input int i, input bit host, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (host ? h_ack[i] : c_vld[i]) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL timeout inst%0d host=%0b got no pulse in 30 cycles required pulse", i, host);
        end
    endtask

    task automatic do_txn(input int i, input bit host, input bit we, input logic [13:0] a,
                          input logic [31:0] d);
        bit ok;
        @(posedge clk); #1;
        push_exp(i, host, we, a, d, cyc + lat_of(i) + 2);
        drive(i, host, we, a, d);
        wait_pulse(i, host, ok);
        h_req[i] = 1'b0; c_req[i] = 1'b0;
    endtask

    // Out-of-range CPU access; additionally watches that chip select never asserts
    task automatic oor_txn(input int i, input bit we, input logic [13:0] a, input logic [31:0] d);
        bit csb_low;
        bit ok;
        @(posedge clk); #1;
        push_exp(i, 1'b0, we, a, d, cyc + lat_of(i) + 2);
        drive(i, 1'b0, we, a, d);
        csb_low = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (!csb[i]) csb_low = 1'b1;
            if (c_vld[i]) begin ok = 1'b1; break; end
        end
        c_req[i] = 1'b0;
        checks++;
        if (csb_low !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL oor_csb inst%0d addr=%h got csb_low=%0b done=%0b required csb_low=0 done=1",
                     i, a, csb_low, ok);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_in[i] = '0;
            h_req[i] = 1'b0; h_we[i] = 1'b0; h_addr[i] = '0; h_wdata[i] = '0;
            last_c[i] = '0; last_h[i] = '0; prev_vld[i] = 1'b0; prev_ack[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({c_vld[i], h_ack[i], c_out[i], h_rdata[i], csb[i], web[i], saddr[i], din[i], busy[i]} !==
                {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 10'h0, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state inst%0d got vld=%b ack=%b out=%h rdata=%h csb=%b web=%b addr=%h din=%h busy=%b required all idle/zero with csb=web=1",
                         i, c_vld[i], h_ack[i], c_out[i], h_rdata[i], csb[i], web[i], saddr[i], din[i], busy[i]);
            end
            rst[i] = 1'b0;
        end
    endtask

    task automatic test_cpu_rw(input int i);
        do_txn(i, 1'b0, 1'b1, 14'h010, 32'h0000_00AB);
        do_txn(i, 1'b0, 1'b0, 14'h010, 32'h0);
        do_txn(i, 1'b1, 1'b1, 14'h020, 32'h1234_5678);
        do_txn(i, 1'b1, 1'b0, 14'h020, 32'h0);
        do_txn(i, 1'b0, 1'b0, 14'h020, 32'h0);
        do_txn(i, 1'b1, 1'b0, 14'h010, 32'h0);
    endtask

    task automatic test_simultaneous(input int i);
        int unsigned c0;
        bit          ok;
        @(posedge clk); #1;
        c0 = cyc;
        push_exp(i, 1'b1, 1'b0, 14'h010, 32'h0, c0 + lat_of(i) + 2);
        push_exp(i, 1'b0, 1'b0, 14'h020, 32'h0, c0 + 2 * lat_of(i) + 5);
        drive(i, 1'b1, 1'b0, 14'h010, 32'h0);
        drive(i, 1'b0, 1'b0, 14'h020, 32'h0);
        wait_pulse(i, 1'b1, ok);
        h_req[i] = 1'b0;
        wait_pulse(i, 1'b0, ok);
        c_req[i] = 1'b0;
    endtask

    task automatic test_out_of_range(input int i);
        do_txn(i, 1'b0, 1'b1, 14'h3FF, 32'hCAFE_F00D);
        do_txn(i, 1'b0, 1'b1, 14'h000, 32'h0000_1111);
        oor_txn(i, 1'b0, 14'h3FFF, 32'h0);
        oor_txn(i, 1'b1, 14'h0400, 32'h5555_5555);
        do_txn(i, 1'b0, 1'b0, 14'h3FF, 32'h0);
        do_txn(i, 1'b0, 1'b0, 14'h000, 32'h0);
    endtask

    task automatic test_reset_mid(input int i);
        @(posedge clk); #1;
        drive(i, 1'b0, 1'b0, 14'h010, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({busy[i], csb[i], c_vld[i]} !== 3'b110) begin
            errors++;
            $display("FAIL mid_wait inst%0d got busy=%b csb=%b vld=%b required busy=1 csb=1 vld=0",
                     i, busy[i], csb[i], c_vld[i]);
        end
        rst[i] = 1'b1; c_req[i] = 1'b0;
        last_c[i] = '0; last_h[i] = '0;
        @(posedge clk); #1;
        checks++;
        if ({csb[i], web[i], busy[i], c_vld[i], c_out[i]} !== {4'b1100, 32'h0}) begin
            errors++;
            $display("FAIL abort inst%0d got csb=%b web=%b busy=%b vld=%b out=%h required csb=1 web=1 busy=0 vld=0 out=0",
                     i, csb[i], web[i], busy[i], c_vld[i], c_out[i]);
        end
        rst[i] = 1'b0;
        repeat (6) @(posedge clk);
        do_txn(i, 1'b0, 1'b0, 14'h010, 32'h0);
    endtask

    task automatic test_back_to_back(input int i);
        logic [13:0] a;
        bit          ok;
        for (int k = 0; k < 4; k++)
            do_txn(i, 1'b0, 1'b1, 14'h100 + 14'(k), 32'hA5A5_0000 + 32'(k * 7 + 3));
        @(posedge clk); #1;
        a = 14'h100;
        push_exp(i, 1'b0, 1'b0, a, 32'h0, cyc + lat_of(i) + 2);
        drive(i, 1'b0, 1'b0, a, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_pulse(i, 1'b0, ok);
            if (k < 3) begin
                a = 14'h100 + 14'(k + 1);
                c_addr[i] = a;
                push_exp(i, 1'b0, 1'b0, a, 32'h0, cyc + lat_of(i) + 3);
            end
        end
        c_req[i] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_rw(0);
        test_simultaneous(0);
        test_out_of_range(0);
        test_reset_mid(0);
        test_back_to_back(0);
        test_cpu_rw(1);
        test_back_to_back(1);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (q0.size() + q1.size() !== 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding completions required 0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
